// File: rtl/cost_monitor.sv
// Epoch supervisor for the squared-error cost accumulator: averages cost per epoch and
// decides convergence or stop. Build with COST_MON_SAT_EN to saturate a wrapped (negative) cost.
module cost_monitor #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 24,
  parameter int LOG2_N    = 2,
  parameter int EPOCH_W   = 16,
  parameter int MAX_EPOCH = 1000,
  parameter int PATIENCE  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_sample_done,
  input  logic [WIDTH-1:0]   i_cost,
  input  logic [WIDTH-1:0]   i_thresh,
  output logic               o_acc_clr,
  output logic [WIDTH-1:0]   o_mean,
  output logic               o_mean_valid,
  output logic [WIDTH-1:0]   o_best,
  output logic [EPOCH_W-1:0] o_epoch,
  output logic               o_busy,
  output logic               o_converged,
  output logic               o_timeout,
`ifdef COST_MON_SAT_EN
  output logic               o_cost_ovf,
`endif
  output logic               o_overrun
);

  localparam int STALL_W = (PATIENCE < 1) ? 1 : $clog2(PATIENCE + 1);
  localparam logic [STALL_W-1:0] PAT_V     = STALL_W'(PATIENCE);
  localparam logic [EPOCH_W-1:0] MAX_EP_V  = EPOCH_W'(MAX_EPOCH);
  localparam logic [EPOCH_W-1:0] EP_SAT    = {EPOCH_W{1'b1}};
  localparam logic [LOG2_N-1:0]  LAST_CNT  = {LOG2_N{1'b1}};
  localparam logic [WIDTH-1:0]   MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};

  if (FRAC >= WIDTH || LOG2_N < 1 || MAX_EPOCH < 1 || PATIENCE < 1) begin : g_param_err
    $error("cost_monitor: invalid parameter set");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SETTLE = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               r_state, w_next_state;
  logic [LOG2_N-1:0]    r_count;
  logic [STALL_W-1:0]   r_stall;
  logic [WIDTH-1:0]     r_mean, r_best;
  logic [EPOCH_W-1:0]   r_epoch;
  logic                 r_acc_clr, r_mean_valid, r_converged, r_timeout, r_overrun;
  logic [WIDTH-1:0]     w_shift;
  logic                 w_below_thresh, w_improve, w_stop;
  logic [STALL_W-1:0]   w_stall_inc;
`ifdef COST_MON_SAT_EN
  logic                 r_cost_ovf;
  assign o_cost_ovf = r_cost_ovf;
`endif

  assign w_shift        = WIDTH'($signed(i_cost) >>> LOG2_N);
  assign w_below_thresh = $signed(r_mean) < $signed(i_thresh);
  assign w_improve      = $signed(r_mean) < $signed(r_best);
  assign w_stall_inc    = r_stall + STALL_W'(1);
  // o_epoch already holds the just-finished epoch when EVAL runs
  assign w_stop         = (!w_improve && (w_stall_inc == PAT_V)) || (r_epoch == MAX_EP_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   w_next_state = IDLE;
      RUN:    if (i_sample_done && (r_count == LAST_CNT)) w_next_state = SETTLE;
              else w_next_state = RUN;
      SETTLE: w_next_state = EVAL;
      EVAL:   if (w_below_thresh || w_stop) w_next_state = DONE;
              else w_next_state = RUN;
      DONE:   w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
    if (i_start) w_next_state = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_stall      <= '0;
      r_mean       <= '0;
      r_best       <= MAX_POS;
      r_epoch      <= '0;
      r_acc_clr    <= 1'b0;
      r_mean_valid <= 1'b0;
      r_converged  <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef COST_MON_SAT_EN
      r_cost_ovf   <= 1'b0;
`endif
    end else begin
      r_acc_clr    <= 1'b0;
      r_mean_valid <= 1'b0;
      if (i_start) begin
        r_count     <= '0;
        r_stall     <= '0;
        r_best      <= MAX_POS;
        r_epoch     <= '0;
        r_acc_clr   <= 1'b1;
        r_converged <= 1'b0;
        r_timeout   <= 1'b0;
        r_overrun   <= 1'b0;
`ifdef COST_MON_SAT_EN
        r_cost_ovf  <= 1'b0;
`endif
      end else begin
        case (r_state)
          RUN: begin
            if (i_sample_done) r_count <= r_count + LOG2_N'(1);
          end
          SETTLE: begin
`ifdef COST_MON_SAT_EN
            if (i_cost[WIDTH-1]) begin
              r_mean     <= MAX_POS;
              r_cost_ovf <= 1'b1;
            end else begin
              r_mean     <= w_shift;
            end
`else
            r_mean <= w_shift;
`endif
            r_mean_valid <= 1'b1;
            r_acc_clr    <= 1'b1;
            if (r_epoch != EP_SAT) r_epoch <= r_epoch + EPOCH_W'(1);
            if (i_sample_done) r_overrun <= 1'b1;
          end
          EVAL: begin
            if (i_sample_done) r_overrun <= 1'b1;
            if (w_below_thresh) begin
              r_converged <= 1'b1;
            end else begin
              if (w_improve) begin
                r_best  <= r_mean;
                r_stall <= '0;
              end else begin
                r_stall <= w_stall_inc;
              end
              if (w_stop) r_timeout <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_acc_clr    = r_acc_clr;
  assign o_mean       = r_mean;
  assign o_mean_valid = r_mean_valid;
  assign o_best       = r_best;
  assign o_epoch      = r_epoch;
  assign o_busy       = (r_state == RUN) || (r_state == SETTLE) || (r_state == EVAL);
  assign o_converged  = r_converged;
  assign o_timeout    = r_timeout;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_cost_monitor.sv
// Directed bench for cost_monitor (PATIENCE=2, MAX_EPOCH=4); epoch means are scoreboarded
// and checked whenever o_mean_valid pulses.
module tb_cost_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_sample_done = 1'b0;
  logic [31:0] i_cost = 32'h0;
  logic [31:0] i_thresh = 32'h0;
  logic        o_acc_clr, o_mean_valid, o_busy, o_converged, o_timeout, o_overrun;
  logic [31:0] o_mean, o_best;
  logic [15:0] o_epoch;
`ifdef COST_MON_SAT_EN
  logic        o_cost_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  cost_monitor #(.WIDTH(32), .FRAC(24), .LOG2_N(2), .EPOCH_W(16), .MAX_EPOCH(4), .PATIENCE(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_sample_done(i_sample_done),
    .i_cost(i_cost), .i_thresh(i_thresh), .o_acc_clr(o_acc_clr), .o_mean(o_mean),
    .o_mean_valid(o_mean_valid), .o_best(o_best), .o_epoch(o_epoch), .o_busy(o_busy),
    .o_converged(o_converged), .o_timeout(o_timeout),
`ifdef COST_MON_SAT_EN
    .o_cost_ovf(o_cost_ovf),
`endif
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every mean pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && o_mean_valid) begin
      if (sb.size() == 0) chk("unexpected_mean_valid", 64'd1, 64'd0);
      else chk("mean", {32'h0, o_mean}, {32'h0, sb.pop_front()});
    end
  end

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // ns samples, cost presented in SETTLE; returns in the EVAL cycle
  task automatic epoch(input int ns, input logic [31:0] cost, input logic [31:0] exp_mean);
    sb.push_back(exp_mean);
    for (int k = 0; k < ns; k++) begin
      i_sample_done = 1'b1;
      tick();
    end
    i_sample_done = 1'b0;
    i_cost = cost;
    chk("settle_no_valid", {63'h0, o_mean_valid}, 64'd0);
    tick();
    chk("eval_valid", {63'h0, o_mean_valid}, 64'd1);
    chk("eval_acc_clr", {63'h0, o_acc_clr}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: asynchronous reset mid-cycle
    tick(); tick();
    rst = 1'b0;
    tick();
    pulse_start();
    i_sample_done = 1'b1; tick(); tick(); i_sample_done = 1'b0;
    chk("busy_before_rst", {63'h0, o_busy}, 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", {63'h0, o_busy}, 64'd0);
    chk("rst_best", {32'h0, o_best}, {32'h0, 32'h7FFFFFFF});
    chk("rst_epoch", {48'h0, o_epoch}, 64'd0);
    chk("rst_mean", {32'h0, o_mean}, 64'd0);
    chk("rst_flags", {58'h0, o_acc_clr, o_mean_valid, o_converged, o_timeout, o_overrun, o_busy}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 2: first epoch, mean 1.0, back in RUN
    i_thresh = 32'h0;
    pulse_start();
    chk("start_acc_clr", {63'h0, o_acc_clr}, 64'd1);
    chk("start_busy", {63'h0, o_busy}, 64'd1);
    tick();
    chk("acc_clr_one_cycle", {63'h0, o_acc_clr}, 64'd0);
    epoch(4, 32'h04000000, 32'h01000000);
    chk("t2_epoch", {48'h0, o_epoch}, 64'd1);
    tick();
    chk("t2_best", {32'h0, o_best}, {32'h0, 32'h01000000});
    chk("t2_busy", {63'h0, o_busy}, 64'd1);
    chk("t2_conv", {63'h0, o_converged}, 64'd0);

    // 3: convergence, then DONE ignores samples
    i_thresh = 32'h00100000;
    epoch(4, 32'h00200000, 32'h00080000);
    tick();
    chk("t3_conv", {63'h0, o_converged}, 64'd1);
    chk("t3_busy", {63'h0, o_busy}, 64'd0);
    chk("t3_timeout", {63'h0, o_timeout}, 64'd0);
    chk("t3_epoch", {48'h0, o_epoch}, 64'd2);
    i_sample_done = 1'b1; tick(); i_sample_done = 1'b0; tick();
    chk("t3_done_overrun", {63'h0, o_overrun}, 64'd0);
    chk("t3_done_best", {32'h0, o_best}, {32'h0, 32'h01000000});

    // 4: patience exhaustion with equal means
    i_thresh = 32'h0;
    pulse_start();
    chk("t4_clear_conv", {63'h0, o_converged}, 64'd0);
    chk("t4_clear_best", {32'h0, o_best}, {32'h0, 32'h7FFFFFFF});
    chk("t4_clear_epoch", {48'h0, o_epoch}, 64'd0);
    epoch(4, 32'h04000000, 32'h01000000);
    tick();
    chk("t4_e1_timeout", {63'h0, o_timeout}, 64'd0);
    epoch(4, 32'h04000000, 32'h01000000);
    tick();
    chk("t4_e2_timeout", {63'h0, o_timeout}, 64'd0);
    chk("t4_e2_busy", {63'h0, o_busy}, 64'd1);
    epoch(4, 32'h04000000, 32'h01000000);
    tick();
    chk("t4_e3_timeout", {63'h0, o_timeout}, 64'd1);
    chk("t4_e3_busy", {63'h0, o_busy}, 64'd0);
    chk("t4_e3_epoch", {48'h0, o_epoch}, 64'd3);

    // 5: restart mid-RUN discards partial samples
    pulse_start();
    i_sample_done = 1'b1; tick(); tick(); i_sample_done = 1'b0;
    pulse_start();
    chk("t5_acc_clr", {63'h0, o_acc_clr}, 64'd1);
    chk("t5_epoch", {48'h0, o_epoch}, 64'd0);
    chk("t5_timeout", {63'h0, o_timeout}, 64'd0);
    i_sample_done = 1'b1; tick(); tick(); tick(); i_sample_done = 1'b0;
    tick(); tick();
    chk("t5_no_valid_3", {63'h0, o_mean_valid}, 64'd0);
    chk("t5_busy", {63'h0, o_busy}, 64'd1);
    epoch(1, 32'h08000000, 32'h02000000);
    chk("t5_epoch1", {48'h0, o_epoch}, 64'd1);
    tick();
    chk("t5_best", {32'h0, o_best}, {32'h0, 32'h02000000});

    // 6: sample in SETTLE raises overrun; epoch limit stops an improving run
    sb.push_back(32'h01800000);
    i_cost = 32'h06000000;
    for (int k = 0; k < 5; k++) begin
      i_sample_done = 1'b1;
      tick();
    end
    i_sample_done = 1'b0;
    chk("t6_valid", {63'h0, o_mean_valid}, 64'd1);
    chk("t6_overrun", {63'h0, o_overrun}, 64'd1);
    tick();
    chk("t6_best", {32'h0, o_best}, {32'h0, 32'h01800000});
    chk("t6_epoch", {48'h0, o_epoch}, 64'd2);
    epoch(4, 32'h05000000, 32'h01400000);
    tick();
    chk("t6_e3_busy", {63'h0, o_busy}, 64'd1);
    epoch(4, 32'h04000000, 32'h01000000);
    tick();
    chk("t6_limit_timeout", {63'h0, o_timeout}, 64'd1);
    chk("t6_limit_busy", {63'h0, o_busy}, 64'd0);
    chk("t6_limit_epoch", {48'h0, o_epoch}, 64'd4);
    chk("t6_limit_best", {32'h0, o_best}, {32'h0, 32'h01000000});
    chk("t6_overrun_sticky", {63'h0, o_overrun}, 64'd1);

    // 7: wrapped accumulator value
    pulse_start();
    chk("t7_overrun_clr", {63'h0, o_overrun}, 64'd0);
`ifdef COST_MON_SAT_EN
    epoch(4, 32'h80000000, 32'h7FFFFFFF);
    chk("t7_cost_ovf", {63'h0, o_cost_ovf}, 64'd1);
    tick();
    chk("t7_conv", {63'h0, o_converged}, 64'd0);
`else
    epoch(4, 32'h80000000, 32'hE0000000);
    tick();
    chk("t7_conv", {63'h0, o_converged}, 64'd1);
`endif
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
